rr_reg_arbiter: RTL
===================

Name: rr_reg_arbiter

Overview:
- Round-robin arbiter that shares one resettable WIDTH-bit register between NREQ requesters.
- Grants one requester at a time, lets it load the register for a bounded burst, then rotates priority.
- Sits in front of the shared D-flop storage and serialises writes from multiple producers; the register output q is the shared value all consumers read.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 8, data/register width in bits
MAX_BURST, 4, maximum writes per grant (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
req  input  NREQ  per-requester request; bit i = requester i
wdata  input  NREQ*WIDTH  packed write data; requester i at bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, registered
owner  output  $clog2(NREQ)  index of current/last granted requester
busy  output  1  high while a grant is active (state BUSY)
q  output  WIDTH  shared register value
upd  output  1  one-cycle pulse in the cycle after q was written

Behaviour:
- Reset (async, immediate, no clock needed): state=IDLE, gnt=0, owner=0, busy=0, q=0, upd=0, rr pointer ptr=0, burst counter cnt=0.
- All other state changes occur on posedge clk only; all outputs are registered.
- State IDLE (gnt=0, busy=0):
  - If req!=0 at the edge, winner = first set bit scanning ptr, ptr+1, ..., wrapping modulo NREQ.
  - Next state is BUSY with gnt<=onehot(winner), owner<=winner, cnt<=0.
  - No write to q on this edge.
  - If req==0, stay IDLE.
- State BUSY (gnt=onehot(owner), busy=1):
  - At each edge with req[owner]=1: q<=wdata[owner], upd<=1, cnt<=cnt+1.
  - Release when either req[owner]=0 at the edge (no write, upd<=0) or the write just made is the MAX_BURST-th (cnt==MAX_BURST-1).
  - On release: state<=IDLE, gnt<=0, ptr<=(owner+1) mod NREQ.
- Latency: req rises before edge k -> gnt visible after edge k -> first write at edge k+1 -> q valid after edge k+1.
- Fairness:
  - After every release, gnt is low for at least one cycle (IDLE).
  - A requester holding req continuously waits at most NREQ-1 other grants.
- Requests from non-owners during BUSY are ignored; they are not queued, only sampled in IDLE.
- Changes on wdata of the owner between edges have no effect; only the value at the edge is captured.
- upd is 0 on any edge where no write occurs.
- owner retains its last value in IDLE.
- ptr wraps from NREQ-1 to 0.
- With MAX_BURST=1, each grant performs exactly one write.
- Reset asserted mid-burst clears q, gnt, busy and ptr immediately. After deassert, arbitration restarts from requester 0.

Test Plan:
- Reset: reset=1 for 20 ns, req=4'b1111 -> q=8'h00, gnt=0000, busy=0, upd=0 throughout. After release, first grant is 0001.
- Single requester: req=0001, wdata0=8'hAA held 2 cycles then dropped -> gnt=0001 after edge 1; q=8'hAA after edge 2; upd high 2 cycles; gnt=0000 on the cycle after req drops; ptr=1.
- Burst cap and rotation: req=1111 constant, wdata=44/33/22/11 for requesters 3..0, MAX_BURST=4 -> grant order 0,1,2,3,0. Each grant makes exactly 4 writes with q=11,22,33,44 respectively, and there is a 1-cycle gnt=0 gap between grants.
- Pointer priority: after requester 0 is served, apply req=0101 -> requester 2 granted before 0. Then req=1001 with ptr=3 -> requester 3 granted.
- Mid-burst data change and drop: owner 1 writes 8'h55, then 8'h66, then drops req -> q=8'h66 stays. Non-owner req=0100 during the burst gets no grant until IDLE.
- Async reset mid-burst: reset pulsed 3 ns between edges during a BUSY write -> q=8'h00 and gnt=0000 before the next edge. The next grant goes to the lowest set req index.

Source files
------------

// File: rtl/rr_reg_arbiter.sv
// rtl/rr_reg_arbiter.sv - round-robin arbiter serialising bounded write bursts into one shared register
module rr_reg_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    output logic [WIDTH-1:0]         q,
    output logic                     upd
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              upd_q, upd_d;

    logic              found;
    logic [OW-1:0]     win;
    logic [OW-1:0]     next_ptr;
    logic              release_grant;

    // Scan ptr, ptr+1, ... modulo NREQ; first set request wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(ptr_q) + i) % NREQ]) begin
                found = 1'b1;
                win   = OW'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    assign next_ptr = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        q_d           = q_q;
        upd_d         = 1'b0;
        release_grant = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    gnt_d   = NREQ'(1) << win;
                    owner_d = win;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (req[owner_q]) begin
                    q_d   = wdata[int'(owner_q)*WIDTH +: WIDTH];
                    upd_d = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(MAX_BURST - 1))
                        release_grant = 1'b1;
                end else begin
                    release_grant = 1'b1;
                end
                if (release_grant) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = next_ptr;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            upd_q   <= upd_d;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = (state_q == BUSY);
    assign q     = q_q;
    assign upd   = upd_q;

endmodule
